// File: rtl/led_chaser_param.sv
// led_chaser_param: N_LED running-light (L/R/ping-pong/bar) with debounced speed/mode/pause keys; q=LEDs, mode_o, speed_o(1=slow), paused_o
module led_chaser_param #(
  parameter int N_LED    = 4,
  parameter int CNT_W    = 32,
  parameter int DIV_FAST = 24999999,
  parameter int DIV_SLOW = 49999999,
  parameter int DEB_CYC  = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_speed,
  input  logic             key_mode,
  input  logic             key_pause,
  output logic [N_LED-1:0] q,
  output logic [1:0]       mode_o,
  output logic             speed_o,
  output logic             paused_o
);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int PW = $clog2(N_LED);
  localparam logic [PW-1:0] LAST = PW'(N_LED - 1);
  logic [2:0] keys, s1, s2, db, press;
  logic [DW-1:0] dc [3];
  logic [CNT_W-1:0] cnt, div;
  logic [PW-1:0] pos, np;
  logic dir, up, rs;
  logic [N_LED:0] one;
  logic [N_LED-1:0] nq;
  assign keys = {key_pause, key_mode, key_speed};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '1;
      s2 <= '1;
      db <= '1;
      for (int i = 0; i < 3; i++) dc[i] <= '0;
    end else begin
      s1 <= keys;
      s2 <= s1;
      for (int i = 0; i < 3; i++)
        if (s2[i] == db[i]) dc[i] <= '0;
        else if (dc[i] == DW'(DEB_CYC - 1)) begin
          db[i] <= s2[i];
          dc[i] <= '0;
        end else dc[i] <= dc[i] + 1'b1;
    end
  always_comb begin
    for (int i = 0; i < 3; i++) press[i] = db[i] & ~s2[i] & (dc[i] == DW'(DEB_CYC - 1));
  end
  always_comb begin
    div = speed_o ? CNT_W'(DIV_SLOW) : CNT_W'(DIV_FAST);
    up = (pos == '0) ? 1'b1 : (pos == LAST) ? 1'b0 : dir;
    np = rs ? (mode_o == 2'd1 ? LAST : '0) :
         mode_o == 2'd2 ? (up ? pos + 1'b1 : pos - 1'b1) :
         mode_o == 2'd1 ? (pos == '0 ? LAST : pos - 1'b1) :
         (pos == LAST ? '0 : pos + 1'b1);
    one = (N_LED + 1)'(1) << np;
    nq = mode_o == 2'd3 ? N_LED'((one << 1) - 1'b1) : one[N_LED-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q        <= '0;
      mode_o   <= '0;
      speed_o  <= 1'b0;
      paused_o <= 1'b0;
      cnt      <= '0;
      pos      <= '0;
      dir      <= 1'b1;
      rs       <= 1'b1;
    end else begin
      if (press[2]) paused_o <= ~paused_o;
      if (press[0] | press[1]) begin
        speed_o <= speed_o ^ press[0];
        mode_o  <= mode_o + {1'b0, press[1]};
        cnt     <= '0;
        q       <= '0;
        rs      <= 1'b1;
      end else if (!paused_o) begin
        if (cnt == div) begin
          cnt <= '0;
          q   <= nq;
          pos <= np;
          dir <= rs | up;
          rs  <= 1'b0;
        end else cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_led_chaser_param.sv
// tb_led_chaser_param: randomized self-checking bench for led_chaser_param against a step-count pattern model
module tb_led_chaser_param;
  localparam int N = 4;
  localparam int DF = 3;
  localparam int DS = 7;
  localparam int DEB = 4;
  localparam int LAT = DEB + 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_speed = 1'b1;
  logic key_mode = 1'b1;
  logic key_pause = 1'b1;
  logic [N-1:0] q;
  logic [1:0] mode_o;
  logic speed_o, paused_o;
  int n_tests = 0;
  int n_fail = 0;
  logic [1:0] m_mode;
  logic m_speed, m_paused;
  int m_e;
  int cd [3];
  led_chaser_param #(.N_LED(N), .CNT_W(8), .DIV_FAST(DF), .DIV_SLOW(DS), .DEB_CYC(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .key_speed(key_speed), .key_mode(key_mode), .key_pause(key_pause),
    .q(q), .mode_o(mode_o), .speed_o(speed_o), .paused_o(paused_o)
  );
  always #5 clk = ~clk;
  function automatic logic [N-1:0] exp_q(input logic [1:0] md, input logic sp, input int e);
    int d, k, i;
    d = sp ? DS : DF;
    if (e / (d + 1) == 0) return '0;
    k = e / (d + 1) - 1;
    i = k % (2 * N - 2);
    case (md)
      2'd0: return N'(1 << (k % N));
      2'd1: return N'(1 << (N - 1 - k % N));
      2'd2: return N'(1 << (i < N ? i : 2 * N - 2 - i));
      default: return N'((1 << (k % N + 1)) - 1);
    endcase
  endfunction
  task automatic model_reset();
    m_mode = 2'd0;
    m_speed = 1'b0;
    m_paused = 1'b0;
    m_e = 0;
    for (int i = 0; i < 3; i++) cd[i] = -1;
  endtask
  task automatic tick(input string tag);
    logic pp, rs;
    logic [N-1:0] eq;
    @(negedge clk);
    pp = m_paused;
    rs = 1'b0;
    for (int i = 0; i < 3; i++)
      if (cd[i] > 0) begin
        cd[i]--;
        if (cd[i] == 0) begin
          cd[i] = -1;
          if (i == 0) begin m_speed = ~m_speed; rs = 1'b1; end
          else if (i == 1) begin m_mode = m_mode + 2'd1; rs = 1'b1; end
          else m_paused = ~m_paused;
        end
      end
    m_e = rs ? 0 : pp ? m_e : m_e + 1;
    eq = exp_q(m_mode, m_speed, m_e);
    n_tests++;
    if (q !== eq) begin
      n_fail++;
      $display("FAIL %s q: got %b want %b (mode %0d speed %0d e %0d)", tag, q, eq, m_mode, m_speed, m_e);
    end
    n_tests++;
    if ({mode_o, speed_o, paused_o} !== {m_mode, m_speed, m_paused}) begin
      n_fail++;
      $display("FAIL %s state: got mode %0d speed %b paused %b want mode %0d speed %b paused %b",
               tag, mode_o, speed_o, paused_o, m_mode, m_speed, m_paused);
    end
  endtask
  task automatic push(input logic [2:0] m, input int hold, input string tag);
    for (int i = 0; i < 3; i++) if (m[i] && hold >= DEB) cd[i] = LAT;
    {key_pause, key_mode, key_speed} = ~m;
    repeat (hold) tick(tag);
    {key_pause, key_mode, key_speed} = 3'b111;
    repeat (LAT + 2) tick(tag);
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({q, mode_o, speed_o, paused_o} !== '0) begin
      n_fail++;
      $display("FAIL reset: got q %b mode %0d speed %b paused %b want all zero", q, mode_o, speed_o, paused_o);
    end
    rst_n = 1'b1;
    model_reset();
  endtask
  task automatic test_shift_left();
    repeat (24) tick("shift_left");
  endtask
  task automatic test_shift_right();
    push(3'b010, DEB, "mode_r_press");
    repeat (24) tick("shift_right");
  endtask
  task automatic test_pingpong();
    push(3'b010, DEB + 1, "mode_pp_press");
    repeat (40) tick("pingpong");
  endtask
  task automatic test_bar_glitch();
    push(3'b010, DEB, "mode_bar_press");
    repeat (20) tick("bar");
    push(3'b010, 2, "glitch");
    repeat (10) tick("bar_after_glitch");
  endtask
  task automatic test_speed_pause();
    push(3'b001, DEB, "speed_press");
    repeat (20) tick("slow");
    push(3'b100, DEB, "pause_press");
    repeat (50) tick("paused");
    push(3'b100, DEB, "resume_press");
    repeat (30) tick("resumed");
  endtask
  task automatic test_back_to_back();
    push(3'b011, DEB, "mode_speed_same_cycle");
    repeat (30) tick("both_applied");
    push(3'b100, DEB, "pause_again");
    push(3'b010, DEB, "mode_while_paused");
    repeat (15) tick("still_paused");
    push(3'b100, DEB, "resume_again");
    repeat (20) tick("resumed_again");
  endtask
  task automatic test_random();
    for (int n = 0; n < 14; n++) begin
      push(3'($urandom_range(1, 7)), $urandom_range(2, 6), "random_press");
      repeat ($urandom_range(0, 30)) tick("random_run");
    end
  endtask
  task automatic test_reset_mid();
    while (m_mode != 2'd2) push(3'b010, DEB, "to_pp");
    if (!m_speed) push(3'b001, DEB, "to_slow");
    if (m_paused) push(3'b100, DEB, "unpause");
    repeat (37) tick("pp_slow");
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (q !== '0) begin
      n_fail++;
      $display("FAIL async_reset_q: got %b want 0000", q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_tests++;
    if ({mode_o, speed_o, paused_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL async_reset_state: got mode %0d speed %b paused %b want 0 0 0", mode_o, speed_o, paused_o);
    end
    repeat (24) tick("after_reset");
  endtask
  initial begin
    model_reset();
    test_reset();
    test_shift_left();
    test_shift_right();
    test_pingpong();
    test_bar_glitch();
    test_speed_pause();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
